// File: rtl/sme_feeder.sv
// sme_feeder: host record front end for the SME string-matching engine.
// Collects newline-terminated 'S'/'P' records, bursts them into SME as
// contiguous chardata beats, then waits for SME's result (or a timeout)
// and hands it to the host on a ready/valid result port.
//
// Handshakes: a host byte moves when in_valid && in_ready on a rising clk;
// a result moves when res_valid && res_ready on a rising clk. res_* hold
// stable while res_valid is high and res_ready is low.
module sme_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [7:0] res_pat_id,
    output logic       res_timeout,
    output logic [2:0] err,
    output logic [2:0] dbg_state
);

    // Buffer is sized for the longer record kind (strings).
    localparam int AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int LW = $clog2(STR_MAX + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
    localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_SKIP     = 3'd2,
        S_BURST    = 3'd3,
        S_WAIT_RES = 3'd4,
        S_REPORT   = 3'd5
    } state_t;

    state_t         state;
    state_t         next_state;
    logic           kind_pat;      // 1: pattern record, 0: string record
    logic [LW-1:0]  len;
    logic [LW-1:0]  idx;           // index of the next beat to put on the bus
    logic [TW-1:0]  tcnt;
    logic [7:0]     pat_id;
    logic [7:0]     buf_mem [STR_MAX];

    logic           accept;
    logic           is_lf;
    logic           is_cr;
    logic           is_s;
    logic           is_p;
    logic [LW-1:0]  limit;
    logic           burst_last;
    logic           timed_out;
    logic           buf_we;

    assign in_ready   = !reset && (state == S_IDLE || state == S_COLLECT || state == S_SKIP);
    assign accept     = in_valid && in_ready;
    assign is_lf      = (in_data == CH_LF);
    assign is_cr      = (in_data == CH_CR);
    assign is_s       = (in_data == CH_S);
    assign is_p       = (in_data == CH_P);
    assign limit      = kind_pat ? PAT_LIM : STR_LIM;
    assign burst_last = (idx == len);
    assign timed_out  = (tcnt == TO_LAST);
    assign buf_we     = (state == S_COLLECT) && accept && !is_lf && !is_cr && (len < limit);

    assign res_valid  = (state == S_REPORT);
    assign res_pat_id = pat_id;
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_s || is_p)          next_state = S_COLLECT;
                    else if (!is_lf && !is_cr) next_state = S_SKIP;
                end
            end
            S_COLLECT: begin
                if (accept && is_lf) next_state = (len == '0) ? S_IDLE : S_BURST;
            end
            S_SKIP: begin
                if (accept && is_lf) next_state = S_IDLE;
            end
            S_BURST: begin
                if (burst_last) next_state = kind_pat ? S_WAIT_RES : S_IDLE;
            end
            S_WAIT_RES: begin
                if (sme_valid || timed_out) next_state = S_REPORT;
            end
            S_REPORT: begin
                if (res_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Record buffer; contents are only meaningful below len, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[len[AW-1:0]] <= in_data;
    end

    // Datapath: record bookkeeping, registered SME beats, result capture, error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_pat      <= 1'b0;
            len           <= '0;
            idx           <= '0;
            tcnt          <= '0;
            pat_id        <= 8'd0;
            sme_chardata  <= 8'd0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= 5'd0;
            res_timeout   <= 1'b0;
            err           <= 3'b000;
        end else begin
            // Strobes are single-cycle unless re-armed by the burst below.
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_s) begin
                            kind_pat <= 1'b0;
                            len      <= '0;
                        end else if (is_p) begin
                            kind_pat <= 1'b1;
                            len      <= '0;
                        end else if (!is_lf && !is_cr) begin
                            err[1] <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (accept && !is_lf && !is_cr) begin
                        if (len < limit) len <= len + LW'(1);
                        else             err[0] <= 1'b1;
                    end
                    // First beat leaves on the same edge that takes the newline.
                    if (accept && is_lf && len != '0) begin
                        sme_chardata  <= buf_mem[0];
                        sme_isstring  <= !kind_pat;
                        sme_ispattern <= kind_pat;
                        idx           <= LW'(1);
                    end
                end
                S_BURST: begin
                    tcnt <= '0;
                    if (!burst_last) begin
                        sme_chardata  <= buf_mem[idx[AW-1:0]];
                        sme_isstring  <= !kind_pat;
                        sme_ispattern <= kind_pat;
                        idx           <= idx + LW'(1);
                    end else if (!kind_pat) begin
                        // A new string restarts the pattern numbering.
                        pat_id <= 8'd0;
                    end
                end
                S_WAIT_RES: begin
                    if (sme_valid) begin
                        res_match   <= sme_match;
                        res_index   <= sme_match_index;
                        res_timeout <= 1'b0;
                    end else if (timed_out) begin
                        res_match   <= 1'b0;
                        res_index   <= 5'd0;
                        res_timeout <= 1'b1;
                        err[2]      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_REPORT: begin
                    if (res_ready) pat_id <= pat_id + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed record tests for sme_feeder with a small SME
// responder model and a beat scoreboard.
module tb_sme_feeder;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 4096;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       sme_valid;
    logic       sme_match;
    logic [4:0] sme_match_index;
    logic       res_valid;
    logic       res_ready;
    logic       res_match;
    logic [4:0] res_index;
    logic [7:0] res_pat_id;
    logic       res_timeout;
    logic [2:0] err;
    logic [2:0] dbg_state;

    sme_feeder #(
        .STR_MAX(STR_MAX),
        .PAT_MAX(PAT_MAX),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sme_chardata   (sme_chardata),
        .sme_isstring   (sme_isstring),
        .sme_ispattern  (sme_ispattern),
        .sme_valid      (sme_valid),
        .sme_match      (sme_match),
        .sme_match_index(sme_match_index),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_match      (res_match),
        .res_index      (res_index),
        .res_pat_id     (res_pat_id),
        .res_timeout    (res_timeout),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_err    = 0;

    logic [8:0] exp_q[$];     // {ispattern, char}
    logic [8:0] got_q[$];
    int         got_cyc[$];
    int         last_acc_cyc;
    int         nl_cyc;
    int         last_pat_cyc;

    // SME responder settings
    bit         sme_en;
    logic       sme_m;
    logic [4:0] sme_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Beat monitor: records every strobed beat with its cycle number.
    always @(negedge clk) begin
        if (sme_isstring || sme_ispattern) begin
            got_q.push_back({sme_ispattern, sme_chardata});
            got_cyc.push_back(cyc);
            if (sme_ispattern) last_pat_cyc = cyc;
        end
    end

    // SME model: answers in the first cycle after a pattern burst ends.
    initial begin
        bit saw;
        saw = 1'b0;
        sme_valid = 1'b0;
        sme_match = 1'b0;
        sme_match_index = 5'd0;
        forever begin
            @(negedge clk);
            if (sme_ispattern) begin
                saw = 1'b1;
            end else if (saw) begin
                saw = 1'b0;
                if (sme_en) begin
                    sme_valid       = 1'b1;
                    sme_match       = sme_m;
                    sme_match_index = sme_i;
                    @(negedge clk);
                    sme_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic rdy;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("in_ready_wait", 32'd0, 32'd1);
        last_acc_cyc = cyc;
        in_valid = 1'b0;
        wait_cycles(gap);
    endtask

    task automatic send_rec(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
        send_byte(8'h0A, 0);
        nl_cyc = last_acc_cyc;
    endtask

    task automatic exp_str(input bit pat, input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({pat, s[i]});
    endtask

    task automatic check_beats(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_beat"}, got_q[i], exp_q[i]);
            check({tag, "_gap"}, got_cyc[i], got_cyc[0] + i);
        end
        if (n > 0) check({tag, "_first_lat"}, got_cyc[0], nl_cyc);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_string(input string body, input int gap);
        exp_str(1'b0, body);
        send_rec({"S", body}, gap);
        wait_cycles(body.len() + 3);
        check_beats({"str_", body});
    endtask

    task automatic wait_result(output int lat);
        int n;
        n = 0;
        lat = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < TIMEOUT + 200);
        if (!res_valid) check("res_valid_wait", 32'd0, 32'd1);
        else            lat = cyc - last_pat_cyc;
    endtask

    task automatic do_pattern(input string rec, input string beats, input bit en,
                              input logic m, input logic [4:0] i,
                              input logic [7:0] pid, input int hold);
        int lat;
        sme_en = en;
        sme_m  = m;
        sme_i  = i;
        exp_str(1'b1, beats);
        send_rec(rec, 0);
        wait_result(lat);
        check_beats({"pat_", beats});
        check("res_latency", lat, en ? 2 : TIMEOUT + 1);
        check("res_match",   res_match,   en ? m : 1'b0);
        check("res_index",   res_index,   en ? i : 5'd0);
        check("res_timeout", res_timeout, !en);
        check("res_pat_id",  res_pat_id,  pid);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", res_valid,   1'b1);
            check("hold_match", res_match,   1'b0);
            check("hold_index", res_index,   5'd0);
            check("hold_tmo",   res_timeout, 1'b1);
            check("hold_pid",   res_pat_id,  pid);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("res_valid_drop", res_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        sme_en    = 1'b1;
        sme_m     = 1'b0;
        sme_i     = 5'd0;
        last_pat_cyc = 0;
        nl_cyc = 0;
        last_acc_cyc = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_strobes",  {sme_isstring, sme_ispattern}, 2'b00);
        check("rst_chardata", sme_chardata, 8'd0);
        check("rst_res",      {res_valid, res_match, res_index, res_pat_id, res_timeout}, 16'd0);
        check("rst_err",      err, 3'b000);
        check("rst_state",    dbg_state, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // basic string + pattern
        do_string("hello", 0);
        check("chardata_hold", sme_chardata, 8'h6f);
        check("strobes_idle",  {sme_isstring, sme_ispattern}, 2'b00);
        do_pattern("Pll", "ll", 1'b1, 1'b1, 5'd2, 8'd0, 0);

        // pattern numbering restarts on each string
        do_string("hello", 0);
        do_pattern("Pxy", "xy", 1'b1, 1'b0, 5'd7, 8'd0, 0);
        do_pattern("Plo", "lo", 1'b1, 1'b1, 5'd3, 8'd1, 0);
        do_string("ab", 0);
        do_pattern("Pa", "a", 1'b1, 1'b1, 5'd0, 8'd0, 0);

        // host stalls inside a record
        do_string("abcd", 3);
        check("err_clean", err, 3'b000);

        // pattern overflow: 10 chars, 8 forwarded
        do_pattern("Pabcdefghij", "abcdefgh", 1'b1, 1'b1, 5'd5, 8'd0, 0);
        check("err_overflow", err, 3'b001);

        // bad command byte: record skipped
        send_rec("X12", 0);
        wait_cycles(4);
        check_beats("bad_cmd");
        check("err_badcmd", err, 3'b011);
        do_pattern("Pa", "a", 1'b1, 1'b0, 5'd9, 8'd1, 0);

        // empty string record: no beats, numbering untouched
        send_rec("S", 0);
        wait_cycles(4);
        check_beats("empty_str");
        check("empty_pid", res_pat_id, 8'd2);

        // timeout with held result
        do_pattern("Pz", "z", 1'b0, 1'b0, 5'd0, 8'd2, 5);
        check("err_timeout", err, 3'b111);

        // operation continues after a timeout
        do_pattern("Pq", "q", 1'b1, 1'b1, 5'd1, 8'd3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
